// File: rtl/bcd_counter_ctrl_if.sv
// Control/status bundle between the BCD counter sequencer, its user controls and the
// 2-digit BCD counter it drives.
//   start/stop/clear : user level controls (sampled every clk)
//   dir              : 0 = count up, 1 = count down
//   target_q1/q0     : up-count stop value (BCD tens/units)
//   q1/q0            : digits read back from the counter
//   cnt_count        : one-cycle step pulse to the counter
//   cnt_mode         : counter direction (0 = up, 1 = down)
//   cnt_clr_n        : active-low clear strobe to the counter
//   busy/done        : sequencer status
// The slave modport is the sequencer's view; master is the user/counter side.
interface bcd_counter_ctrl_if;
  logic       start;
  logic       stop;
  logic       clear;
  logic       dir;
  logic [3:0] target_q1;
  logic [3:0] target_q0;
  logic [3:0] q1;
  logic [3:0] q0;
  logic       cnt_count;
  logic       cnt_mode;
  logic       cnt_clr_n;
  logic       busy;
  logic       done;

  modport slave (
    input  start, stop, clear, dir, target_q1, target_q0, q1, q0,
    output cnt_count, cnt_mode, cnt_clr_n, busy, done
  );

  modport master (
    output start, stop, clear, dir, target_q1, target_q0, q1, q0,
    input  cnt_count, cnt_mode, cnt_clr_n, busy, done
  );
endinterface

// File: rtl/bcd_counter_ctrl.sv
// Run/stop/clear sequencer for a 2-digit BCD counter. Divides clk into count ticks of DIV
// cycles, issues one-cycle step pulses to the counter, and stops when the counter digits
// reach the (saturated) BCD target when counting up, or 00 when counting down.
//   clk    : system clock, rising edge
//   rstn   : asynchronous active-low reset
//   bus_io : control/status bundle (slave view), see bcd_counter_ctrl_if
// All outputs are registered. Input priority each cycle: clear > stop > start.
module bcd_counter_ctrl #(
  parameter int unsigned DIV   = 4,
  parameter int unsigned DIV_W = 16
) (
  input  logic              clk,
  input  logic              rstn,
  bcd_counter_ctrl_if.slave bus_io
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StRun   = 3'd1,
    StPause = 3'd2,
    StDone  = 3'd3,
    StClear = 3'd4
  } state_e;

  localparam logic [DIV_W-1:0] PrescMax = DIV_W'(DIV - 1);

  state_e           state_q;
  logic [DIV_W-1:0] presc_q;
  logic             cnt_count_q;
  logic             cnt_mode_q;
  logic             cnt_clr_n_q;
  logic             busy_q;
  logic             done_q;

  logic [3:0] lim_q1;
  logic [3:0] lim_q0;
  logic       at_lim_up;
  logic       at_lim_dn;
  logic       at_limit;
  logic       at_limit_dir;
  logic       presc_wrap;

  // Non-BCD target digits behave as 9.
  function automatic logic [3:0] sat_digit(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  always_comb begin
    lim_q1       = sat_digit(bus_io.target_q1);
    lim_q0       = sat_digit(bus_io.target_q0);
    at_lim_up    = (bus_io.q1 == lim_q1) && (bus_io.q0 == lim_q0);
    at_lim_dn    = (bus_io.q1 == 4'd0) && (bus_io.q0 == 4'd0);
    at_limit     = cnt_mode_q ? at_lim_dn : at_lim_up;
    // On start the limit must be judged against the direction being latched, not the old one.
    at_limit_dir = bus_io.dir ? at_lim_dn : at_lim_up;
    presc_wrap   = (presc_q == PrescMax);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StIdle;
      presc_q     <= '0;
      cnt_count_q <= 1'b0;
      cnt_mode_q  <= 1'b0;
      cnt_clr_n_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      cnt_count_q <= 1'b0;
      cnt_clr_n_q <= 1'b1;
      // CLEAR always returns to IDLE so the strobe stays exactly one cycle wide.
      if (bus_io.clear && (state_q != StClear)) begin
        state_q     <= StClear;
        cnt_clr_n_q <= 1'b0;
        busy_q      <= 1'b0;
        done_q      <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (bus_io.start && !bus_io.stop) begin
              cnt_mode_q <= bus_io.dir;
              presc_q    <= '0;
              if (at_limit_dir) begin
                state_q <= StDone;
                done_q  <= 1'b1;
              end else begin
                state_q <= StRun;
                busy_q  <= 1'b1;
              end
            end
          end
          StRun: begin
            if (bus_io.stop) begin
              // Prescaler holds, so a wrap suppressed here fires on the first edge after resume.
              state_q <= StPause;
            end else if (at_limit && !cnt_count_q) begin
              // q1/q0 are stale while a pulse is in flight, so only trust at_limit without one.
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              presc_q <= presc_wrap ? '0 : presc_q + DIV_W'(1);
              if (presc_wrap && !at_limit) begin
                cnt_count_q <= 1'b1;
              end
            end
          end
          StPause: begin
            if (bus_io.start && !bus_io.stop) begin
              state_q <= StRun;
            end
          end
          StDone: begin
            // Held until clear.
          end
          StClear: begin
            state_q <= StIdle;
            presc_q <= '0;
          end
          default: begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus_io.cnt_count = cnt_count_q;
  assign bus_io.cnt_mode  = cnt_mode_q;
  assign bus_io.cnt_clr_n = cnt_clr_n_q;
  assign bus_io.busy      = busy_q;
  assign bus_io.done      = done_q;

endmodule

// File: doc/bcd_counter_ctrl.md
Name: bcd_counter_ctrl

Overview:
Run/stop/clear sequencer for the 2-digit BCD counter (BcdCounter_2digit). It divides the system clock into count ticks, drives the counter's count and mode inputs and a registered clear strobe, and stops the count at a BCD target (up) or at 00 (down). It sits between user start/stop/clear controls and the counter, reading back the counter's Q1/Q0 digits.

Parameters:
DIV, 4, clk cycles per count tick; legal range ≥ 2.
DIV_W, 16, width of the prescaler counter; must satisfy 2^DIV_W ≥ DIV.

Ports:
clk  input  1  system clock, rising edge.
rstn  input  1  asynchronous active-low reset.
start  input  1  level, sampled each clk; begin or resume counting.
stop  input  1  level, sampled each clk; pause counting.
clear  input  1  level, sampled each clk; abort and clear the counter.
dir  input  1  0 = count up, 1 = count down; latched on IDLE->RUN.
target_q1  input  4  up-count stop value, tens digit (BCD).
target_q0  input  4  up-count stop value, units digit (BCD).
q1  input  4  counter tens digit (from Q1).
q0  input  4  counter units digit (from Q0).
cnt_count  output  1  to counter count input; one-cycle pulse per step.
cnt_mode  output  1  to counter mode input; 0 = up, 1 = down.
cnt_clr_n  output  1  registered active-low clear to the counter rstn (ANDed with system rstn at top level).
busy  output  1  high in RUN and PAUSE.
done  output  1  high in DONE.

Behaviour:
- Reset values (rstn low): state IDLE, prescaler 0, cnt_count 0, cnt_mode 0, cnt_clr_n 1, busy 0, done 0.
- All outputs are registered. State encoding: IDLE=0, RUN=1, PAUSE=2, DONE=3, CLEAR=4.
- Input priority each cycle: clear > stop > start.
- Limit: when cnt_mode=0 the limit is {target_q1,target_q0}, with any digit >9 treated as 9. When cnt_mode=1 the limit is 00. at_limit = ({q1,q0} == limit).
- IDLE:
  - start -> cnt_mode <= dir, prescaler <= 0.
  - The next state is DONE if at_limit (evaluated with the new mode), otherwise RUN.
- RUN:
  - The prescaler increments each cycle and wraps at DIV-1.
  - On the wrap cycle, if !at_limit, cnt_count = 1 in the following cycle only.
  - The counter updates on that edge, so q1/q0 are valid before the next wrap.
  - RUN -> DONE when at_limit and cnt_count = 0 (no pulse in flight).
  - stop -> PAUSE.
- PAUSE: prescaler frozen; cnt_count 0; start -> RUN, with the prescaler resuming from its held value.
- DONE: cnt_count 0; done 1; start and stop ignored; exits only via clear.
- CLEAR: entered from any state on clear.
  - cnt_clr_n is 0 for exactly one cycle, and cnt_count is 0.
  - Next state IDLE with prescaler 0; cnt_mode is retained.
- dir changes outside IDLE are ignored. cnt_mode never changes while cnt_count is 1.
- A stop arriving on the same cycle as a prescaler wrap suppresses that step: no cnt_count pulse.
- A clear arriving while cnt_count is 1: the pulse completes, then cnt_clr_n goes low on the next cycle.
- rstn asserted mid-operation returns everything to reset values immediately (asynchronous), regardless of state.

Test Plan:
- DIV=4, dir=0, target 05, start held 1 cycle: exactly 5 cnt_count pulses, spaced 4 cycles apart. Q reaches 05, done=1, busy=0. No 6th pulse.
- dir=1 from counter value 03: cnt_mode=1, 3 pulses, then DONE at 00. Start with counter at 00 -> DONE directly with 0 pulses.
- Up count to target 12, pause on stop after the 4th pulse for 20 cycles, then start: no pulses during PAUSE. Prescaler phase is preserved on resume, and the count ends at 12 with 12 total pulses.
- Clear in RUN, in DONE, and simultaneously with start: a one-cycle cnt_clr_n low each time, then state IDLE; clear wins over start.
- Target digits 0xF/0xA: treated as 99; the count stops at 99 after 99 pulses. dir toggled during RUN: cnt_mode is unchanged.
- rstn pulled low mid-RUN while cnt_count=1: all outputs go to reset values in the same cycle without waiting for a clk edge.
